// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared state enum and default sizes for the multi-port register file
package reg_file_pkg;
  localparam int XLEN_D = 32;
  localparam int NREG_D = 32;
  typedef enum logic {INIT, RUN} state_t;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write bits with write-bypass-aware busy outputs
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREG = NREG_D,
  parameter int NRP  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              set,
  input  logic [AW-1:0]     set_addr,
  input  logic [1:0]        wen,
  input  logic [2*AW-1:0]   waddr,
  input  logic [NRP*AW-1:0] raddr,
  output logic [NRP-1:0]    busy_o
);
  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);
  logic [NREG-1:0] busy;
  logic            set_ok;
  assign set_ok = run && set && set_addr != '0 && {1'b0, set_addr} < NREG_W;
  // the set is applied after the clears so a new producer wins over a same-cycle write
  always_ff @(posedge clk) begin
    if (!reset) busy <= '0;
    else begin
      for (int j = 0; j < 2; j++) if (wen[j]) busy[waddr[j*AW +: AW]] <= 1'b0;
      if (set_ok) busy[set_addr] <= 1'b1;
    end
  end
  for (genvar k = 0; k < NRP; k++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr[k*AW +: AW];
    assign busy_o[k] = run && {1'b0, ra} < NREG_W && busy[ra] &&
                       !((wen[0] && waddr[0 +: AW] == ra) || (wen[1] && waddr[AW +: AW] == ra));
  end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with zeroing sweep after reset, write bypass and scoreboard
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter  int XLEN = XLEN_D,
  parameter  int NREG = NREG_D,
  parameter  int NRP  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRP*AW-1:0]   raddr_i,
  output logic [NRP*XLEN-1:0] rdata_o,
  input  logic [1:0]          wen_c,
  input  logic [2*AW-1:0]     waddr_i,
  input  logic [2*XLEN-1:0]   wdata_i,
  input  logic                sb_set_c,
  input  logic [AW-1:0]       sb_addr_i,
  output logic [NRP-1:0]      sb_busy_o,
  output logic                ready_o
);
  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);
  state_t          state, state_n;
  logic [AW-1:0]   idx, idx_n;
  logic [XLEN-1:0] regs [NREG];
  logic [AW-1:0]   wa [2];
  logic [XLEN-1:0] wd [2];
  logic [1:0]      we;
  assign ready_o = state == RUN;
  for (genvar j = 0; j < 2; j++) begin : g_wr
    assign wa[j] = waddr_i[j*AW +: AW];
    assign wd[j] = wdata_i[j*XLEN +: XLEN];
    assign we[j] = ready_o && wen_c[j] && wa[j] != '0 && {1'b0, wa[j]} < NREG_W;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= INIT;
      idx   <= AW'(1);
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end
  always_comb begin
    state_n = (state == INIT && idx == AW'(NREG - 1)) ? RUN : state;
    idx_n   = (state == INIT) ? idx + 1'b1 : idx;
  end
  // no reset on the array itself: contents become defined by the INIT sweep
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == INIT) regs[idx] <= '0;
      for (int j = 0; j < 2; j++) if (we[j]) regs[wa[j]] <= wd[j];
    end
  end
  for (genvar k = 0; k < NRP; k++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr_i[k*AW +: AW];
    assign rdata_o[k*XLEN +: XLEN] = (we[1] && wa[1] == ra) ? wd[1] :
                                     (we[0] && wa[0] == ra) ? wd[0] :
                                     (ready_o && ra != '0 && {1'b0, ra} < NREG_W) ? regs[ra] : '0;
  end
  reg_scoreboard #(.NREG(NREG), .NRP(NRP), .AW(AW)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .run      (ready_o),
    .set      (sb_set_c),
    .set_addr (sb_addr_i),
    .wen      (we),
    .waddr    (waddr_i),
    .raddr    (raddr_i),
    .busy_o   (sb_busy_o)
  );
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: scoreboard-queue bench for reg_file_mp with default sizes
module tb_reg_file_mp;
  logic        clk = 0;
  logic        reset = 0;
  logic [9:0]  raddr = '0;
  logic [63:0] rdata;
  logic [1:0]  wen = '0;
  logic [9:0]  waddr = '0;
  logic [63:0] wdata = '0;
  logic        sb_set = 0;
  logic [4:0]  sb_addr = '0;
  logic [1:0]  sb_busy;
  logic        ready;
  int          checks = 0;
  int          errors = 0;
  int          n;
  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  reg_file_mp dut (
    .clk       (clk),
    .reset     (reset),
    .raddr_i   (raddr),
    .rdata_o   (rdata),
    .wen_c     (wen),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .sb_set_c  (sb_set),
    .sb_addr_i (sb_addr),
    .sb_busy_o (sb_busy),
    .ready_o   (ready)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] obs(input int kind);
    case (kind)
      0:       return rdata[31:0];
      1:       return rdata[63:32];
      2:       return {31'b0, sb_busy[0]};
      3:       return {31'b0, sb_busy[1]};
      default: return {31'b0, ready};
    endcase
  endfunction
  task automatic push(input string tag, input int kind, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.exp = exp;
    q.push_back(e);
  endtask
  task automatic sample();
    exp_t e;
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(e.tag, obs(e.kind), e.exp);
    end
  endtask
  task automatic idle();
    wen = '0; waddr = '0; wdata = '0; sb_set = 0; sb_addr = '0; raddr = '0;
  endtask
  task automatic drive(input logic [1:0] w, input logic [4:0] wa0, input logic [4:0] wa1,
                       input logic [31:0] wd0, input logic [31:0] wd1,
                       input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic s, input logic [4:0] sa);
    @(posedge clk); #1;
    wen = w; waddr = {wa1, wa0}; wdata = {wd1, wd0};
    raddr = {ra1, ra0}; sb_set = s; sb_addr = sa;
  endtask
  task automatic rst_release();
    @(posedge clk); #1;
    reset = 0;
    idle();
    @(posedge clk); #1;
    reset = 1;
  endtask
  task automatic wait_ready(output int cnt);
    cnt = 0;
    @(negedge clk);
    while (!ready && cnt < 100) begin
      cnt++;
      if (cnt == 5) begin
        chk("init_rdata", rdata[31:0], 32'h0);
        chk("init_busy", {30'b0, sb_busy}, 32'h0);
      end
      @(negedge clk);
    end
    idle();
  endtask
  task automatic read_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'(2*i), 5'(2*i+1), 1'b0, 5'd0);
      push(tag, 0, 32'h0);
      push(tag, 1, 32'h0);
      push(tag, 2, 32'h0);
      push(tag, 3, 32'h0);
      sample();
    end
  endtask
  initial begin
    // initial reset; writes and a scoreboard set during INIT must be ignored
    @(posedge clk); #1;
    reset = 1;
    wen = 2'b11; waddr = {5'd4, 5'd3}; wdata = {32'h44, 32'h33};
    sb_set = 1; sb_addr = 5'd6; raddr = {5'd6, 5'd3};
    wait_ready(n);
    chk("init_len", 32'(n), 32'd31);
    chk("ready_run", {31'b0, ready}, 32'h1);
    read_all("sweep_zero");
    // bypass on port 0, then stored value
    drive(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 5'd5, 5'd5, 1'b0, 5'd0);
    push("byp0_p0", 0, 32'hDEADBEEF);
    push("byp0_p1", 1, 32'hDEADBEEF);
    sample();
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0);
    push("stored5", 0, 32'hDEADBEEF);
    push("rd_x0", 1, 32'h0);
    sample();
    // both ports to register 7: port 1 wins in bypass and storage
    drive(2'b11, 5'd7, 5'd7, 32'h1, 32'h2, 5'd7, 5'd5, 1'b0, 5'd0);
    push("dual_byp", 0, 32'h2);
    push("other_rd", 1, 32'hDEADBEEF);
    sample();
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0);
    push("dual_store", 0, 32'h2);
    sample();
    // write to x0 discarded, top register writable
    drive(2'b11, 5'd0, 5'd31, 32'hFF, 32'hA5A5_0031, 5'd0, 5'd31, 1'b0, 5'd0);
    push("x0_byp", 0, 32'h0);
    push("r31_byp", 1, 32'hA5A5_0031);
    sample();
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd31, 1'b0, 5'd0);
    push("x0_store", 0, 32'h0);
    push("r31_store", 1, 32'hA5A5_0031);
    sample();
    // scoreboard: set, clear by write, set+write keeps set
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd9, 1'b1, 5'd9);
    push("sb_pre", 2, 32'h0);
    sample();
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0);
    push("sb_set0", 2, 32'h1);
    push("sb_set1", 3, 32'h1);
    sample();
    drive(2'b01, 5'd9, 5'd0, 32'h99, 32'h0, 5'd9, 5'd5, 1'b0, 5'd0);
    push("sb_wr_hit", 2, 32'h0);
    push("sb_other", 3, 32'h0);
    push("wr9_byp", 0, 32'h99);
    sample();
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0);
    push("sb_cleared", 2, 32'h0);
    sample();
    drive(2'b10, 5'd0, 5'd9, 32'h0, 32'h999, 5'd9, 5'd0, 1'b1, 5'd9);
    push("sb_setwr_hit", 2, 32'h0);
    sample();
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd0);
    push("sb_setwr_after", 2, 32'h1);
    push("sb_x0_set", 3, 32'h0);
    push("wr9_store", 0, 32'h999);
    sample();
    // reset during RUN with live data and a busy bit
    rst_release();
    wait_ready(n);
    chk("run_rst_len", 32'(n), 32'd31);
    read_all("run_rst_zero");
    // reset part-way through the INIT sweep
    drive(2'b01, 5'd12, 5'd0, 32'h1234, 32'h0, 5'd0, 5'd0, 1'b1, 5'd12);
    rst_release();
    repeat (9) @(posedge clk);
    rst_release();
    wait_ready(n);
    chk("init_rst_len", 32'(n), 32'd31);
    read_all("init_rst_zero");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width in bits.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers (2..64); AW = clog2(NREG).
REQ-003 SHALL have parameter NRP, default 2, number of read ports (1..4).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port raddr_i  input  NRP*AW  packed read addresses; port k occupies bits [k*AW +: AW].
REQ-007 SHALL have port rdata_o  output  NRP*XLEN  packed read data, port k at [k*XLEN +: XLEN].
REQ-008 SHALL have port wen_c  input  2  write enables, bit j for write port j.
REQ-009 SHALL have port waddr_i  input  2*AW  packed write addresses.
REQ-010 SHALL have port wdata_i  input  2*XLEN  packed write data.
REQ-011 SHALL have port sb_set_c  input  1  marks register sb_addr_i as pending-write (scoreboard set).
REQ-012 SHALL have port sb_addr_i  input  AW  scoreboard set address.
REQ-013 SHALL have port sb_busy_o  output  NRP  per read port, pending-write flag of the addressed register.
REQ-014 SHALL have port ready_o  output  1  high when array initialised and accepting writes.

Function
REQ-015 SHALL implement FSM states INIT and RUN; reset (low) forces INIT with clear index = 1.
REQ-016 In INIT SHALL write zero to register[index] each cycle, index++; after writing NREG-1, next state RUN; duration exactly NREG-1 cycles after reset release.
REQ-017 In INIT SHALL hold ready_o=0, drive all rdata_o=0, sb_busy_o=0, and ignore wen_c and sb_set_c.
REQ-018 In RUN SHALL hold ready_o=1 and write wdata_i[j] to register[waddr_i[j]] at the clock edge when wen_c[j]=1.
REQ-019 Writes to address 0 or to addresses >= NREG SHALL be discarded.
REQ-020 Both write ports to the same address in one cycle: port 1 data SHALL win.
REQ-021 Reads SHALL be combinational (zero latency); address 0 or >= NREG reads 0.
REQ-022 SHALL bypass same-cycle writes: if wen_c[j] and waddr_i[j]==raddr_i[k]!=0, rdata_o[k]=wdata_i[j], port 1 over port 0.
REQ-023 Scoreboard: NREG busy bits, bit 0 constant 0; set on sb_set_c in RUN (addr !=0, <NREG); cleared by any RUN write to that register.
REQ-024 Same-cycle set and clear of one register SHALL leave it set (new producer wins).
REQ-025 sb_busy_o[k] SHALL equal busy[raddr_i[k]] AND NOT (a write to raddr_i[k] in this cycle).

Reset
REQ-026 Reset SHALL clear all busy bits, set state INIT, index 1; ready_o=0 in the cycle after reset sampled low.
REQ-027 Reset asserted mid-INIT or mid-RUN SHALL restart the full clear sequence from index 1.
REQ-028 Register contents SHALL be defined only via the INIT sweep (no per-entry reset fan-out).

Structure
REQ-029 Shared package reg_file_pkg SHALL hold the state enum (INIT, RUN) and XLEN/NREG default constants.
REQ-030 Scoreboard SHALL be a sub-module reg_scoreboard (busy array, set/clear, bypass-aware busy outputs).

Verification
REQ-031 Reset low 1 cycle then high, NREG=32 -> ready_o=0 for 31 cycles, then 1; all reads return 0.
REQ-032 RUN: wen_c=01, waddr0=5, wdata0=0xDEADBEEF, raddr0=5 same cycle -> rdata0=0xDEADBEEF (bypass); next cycle still 0xDEADBEEF.
REQ-033 wen_c=11, both waddr=7, wdata0=0x1, wdata1=0x2 -> register 7 reads 0x2; write to x0 of 0xFF -> x0 reads 0.
REQ-034 sb_set_c addr 9; next cycle raddr=9 -> sb_busy=1; write 9 -> same-cycle sb_busy=0, stays 0; set+write 9 same cycle -> busy=1 after.
REQ-035 Reset asserted at INIT index 10 and during RUN with data in regs -> sweep restarts, ready_o low 31 cycles, all regs 0, busy bits 0.
